// File: rtl/video_mode_gen_if.sv
// ---------------------------------------------------------------------------
// video_mode_gen_if
// Bundles the pixel-source handshake and the VGA output bus of video_mode_gen.
//   test_picture            : selects the internal test pattern
//   red/green/blue_byte     : show-ahead source pixel
//   fetch_next              : source pixel consumed, advance the source
//   line_repeat             : source rewinds to the start of the current line
//   fifo_reset              : start of vertical blank, source restarts frame
//   vga_hsync/vga_vsync     : sync pulses (polarity set by the generator)
//   vga_blank/vga_vblank    : combined blank / vertical blank, active high
//   vga_r/vga_g/vga_b       : pixel colour
// master = the generator, slave = the pixel source / display side.
// ---------------------------------------------------------------------------
interface video_mode_gen_if;
  logic       test_picture;
  logic [7:0] red_byte;
  logic [7:0] green_byte;
  logic [7:0] blue_byte;
  logic       fetch_next;
  logic       line_repeat;
  logic       fifo_reset;
  logic       vga_hsync;
  logic       vga_vsync;
  logic       vga_blank;
  logic       vga_vblank;
  logic [7:0] vga_r;
  logic [7:0] vga_g;
  logic [7:0] vga_b;

  modport master (
    input  test_picture, red_byte, green_byte, blue_byte,
    output fetch_next, line_repeat, fifo_reset,
    output vga_hsync, vga_vsync, vga_blank, vga_vblank,
    output vga_r, vga_g, vga_b
  );

  modport slave (
    output test_picture, red_byte, green_byte, blue_byte,
    input  fetch_next, line_repeat, fifo_reset,
    input  vga_hsync, vga_vsync, vga_blank, vga_vblank,
    input  vga_r, vga_g, vga_b
  );
endinterface

// File: rtl/video_mode_gen.sv
// ---------------------------------------------------------------------------
// video_mode_gen
// Programmable VGA-style timing generator with integer pixel/line scaling.
// Walks a raster of FRAME_X x FRAME_Y pixel clocks, pulls pixels from a
// show-ahead source (fetch_next / line_repeat / fifo_reset) and drives
// registered sync, blank and colour outputs one cycle after the raster
// position that produced them.
// Ports:
//   clk_pixel : pixel clock, sole clock
//   reset     : synchronous, active-high reset
//   vid       : video_mode_gen_if.master (source handshake + VGA bus)
// ---------------------------------------------------------------------------
module video_mode_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int SCALE_X   = 1,
  parameter int SCALE_Y   = 1
) (
  input  logic              clk_pixel,
  input  logic              reset,
  video_mode_gen_if.master  vid
);

  localparam int FRAME_X  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int FRAME_Y  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int CXW      = $clog2(FRAME_X);
  localparam int CYW      = $clog2(FRAME_Y);
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  logic [CXW-1:0] r_cx;
  logic [CYW-1:0] r_cy;
  logic [23:0]    r_pix;
  logic           r_hsync;
  logic           r_vsync;
  logic           r_blank;
  logic           r_vblank;
  logic [23:0]    r_rgb;

  // Counters widened to 32 bits so every comparison against the integer
  // timing parameters is full width, even when a boundary equals FRAME_X.
  logic [31:0]    w_x;
  logic [31:0]    w_y;
  logic           w_active;
  logic           w_fetch;
  logic           w_line_rep;
  logic           w_fifo_rst;
  logic           w_hs_on;
  logic           w_vs_on;
  logic [23:0]    w_src;
  logic [23:0]    w_pattern;

  assign w_x = 32'(r_cx);
  assign w_y = 32'(r_cy);

  assign w_active   = (w_x < H_ACTIVE) && (w_y < V_ACTIVE);
  assign w_fetch    = w_active && ((w_x % SCALE_X) == 0) && !reset;
  // The source replays a line SCALE_Y times; every copy but the last rewinds.
  assign w_line_rep = (w_x == H_ACTIVE) && (w_y < V_ACTIVE) &&
                      ((w_y % SCALE_Y) != (SCALE_Y - 1)) && !reset;
  assign w_fifo_rst = (w_x == 0) && (w_y == V_ACTIVE) && !reset;
  assign w_hs_on    = (w_x >= HS_START) && (w_x < HS_END);
  assign w_vs_on    = (w_y >= VS_START) && (w_y < VS_END);

  // A pixel fetched this cycle is shown on the very next output cycle, so the
  // colour path bypasses the pixel register on a fetch.
  assign w_src      = w_fetch ? {vid.red_byte, vid.green_byte, vid.blue_byte} : r_pix;
  assign w_pattern  = {w_x[7:0], w_y[7:0], {8{w_x[4] ^ w_y[4]}}};

  assign vid.fetch_next  = w_fetch;
  assign vid.line_repeat = w_line_rep;
  assign vid.fifo_reset  = w_fifo_rst;
  assign vid.vga_hsync   = r_hsync;
  assign vid.vga_vsync   = r_vsync;
  assign vid.vga_blank   = r_blank;
  assign vid.vga_vblank  = r_vblank;
  assign vid.vga_r       = r_rgb[23:16];
  assign vid.vga_g       = r_rgb[15:8];
  assign vid.vga_b       = r_rgb[7:0];

  // Raster position.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      r_cx <= '0;
      r_cy <= '0;
    end else if (w_x == FRAME_X - 1) begin
      r_cx <= '0;
      r_cy <= (w_y == FRAME_Y - 1) ? '0 : r_cy + CYW'(1);
    end else begin
      r_cx <= r_cx + CXW'(1);
    end
  end

  // Pixel register: holds the fetched pixel for the SCALE_X cycles it covers.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      r_pix <= '0;
    end else if (w_fetch) begin
      r_pix <= {vid.red_byte, vid.green_byte, vid.blue_byte};
    end
  end

  // Registered video outputs, one cycle behind (cx, cy). Everything is decoded
  // from the counters, so test_picture switching cannot disturb sync/blank.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      r_hsync  <= ~HSYNC_POL;
      r_vsync  <= ~VSYNC_POL;
      r_blank  <= 1'b1;
      r_vblank <= 1'b0;
      r_rgb    <= '0;
    end else begin
      r_hsync  <= w_hs_on ? HSYNC_POL : ~HSYNC_POL;
      r_vsync  <= w_vs_on ? VSYNC_POL : ~VSYNC_POL;
      r_blank  <= ~w_active;
      r_vblank <= (w_y >= V_ACTIVE);
      if (!w_active) begin
        r_rgb <= '0;
      end else if (vid.test_picture) begin
        r_rgb <= w_pattern;
      end else begin
        r_rgb <= w_src;
      end
    end
  end

endmodule

// File: tb/tb_video_mode_gen.sv
// ---------------------------------------------------------------------------
// tb_video_mode_gen
// Three generators share one small raster (H 8/2/2/4, V 4/1/1/2) and differ
// in scaling and sync polarity:
//   dut0 : scale 1x1, polarity low   (source image is a ramp 1,2,3,...)
//   dut1 : scale 2x2, polarity low   (random source image)
//   dut2 : scale 4x4, polarity high  (random source image)
// The bench acts as the pixel source (a stream pointer into a flat image
// that advances on fetch_next, rewinds a line on line_repeat and restarts on
// fifo_reset) and predicts every output from the raster position derived
// arithmetically from the cycle count since reset release.
// ---------------------------------------------------------------------------
module tb_video_mode_gen;

  localparam int H_ACT  = 8;
  localparam int H_FP   = 2;
  localparam int H_SYNC = 2;
  localparam int H_BP   = 4;
  localparam int V_ACT  = 4;
  localparam int V_FP   = 1;
  localparam int V_SYNC = 1;
  localparam int V_BP   = 2;
  localparam int FX     = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int FY     = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int ND     = 3;
  localparam int LAST_CYC = 3300;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tp  = 1'b0;
  int   cyc = -4;       // index of the current cycle, 0 = first after release
  int   t   = 0;        // cycles since the most recent reset release
  int   rst_left = 0;
  int   n_checks = 0;
  int   n_err    = 0;

  always #5 clk = ~clk;

  video_mode_gen_if vif0 ();
  video_mode_gen_if vif1 ();
  video_mode_gen_if vif2 ();

  video_mode_gen #(
    .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .SCALE_X(1), .SCALE_Y(1)
  ) dut0 (.clk_pixel(clk), .reset(rst), .vid(vif0));

  video_mode_gen #(
    .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .SCALE_X(2), .SCALE_Y(2)
  ) dut1 (.clk_pixel(clk), .reset(rst), .vid(vif1));

  video_mode_gen #(
    .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .SCALE_X(4), .SCALE_Y(4)
  ) dut2 (.clk_pixel(clk), .reset(rst), .vid(vif2));

  function automatic int cfg_sx(int d);
    case (d)
      0:       return 1;
      1:       return 2;
      default: return 4;
    endcase
  endfunction

  function automatic int cfg_sy(int d);
    case (d)
      0:       return 1;
      1:       return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic cfg_pol(int d);
    return (d == 2);
  endfunction

  // Pixel source: flat image per DUT plus a stream pointer.
  logic [23:0] img [ND][32];
  int          p   [ND];
  int          pi  [ND];

  assign vif0.red_byte   = img[0][pi[0]][23:16];
  assign vif0.green_byte = img[0][pi[0]][15:8];
  assign vif0.blue_byte  = img[0][pi[0]][7:0];
  assign vif1.red_byte   = img[1][pi[1]][23:16];
  assign vif1.green_byte = img[1][pi[1]][15:8];
  assign vif1.blue_byte  = img[1][pi[1]][7:0];
  assign vif2.red_byte   = img[2][pi[2]][23:16];
  assign vif2.green_byte = img[2][pi[2]][15:8];
  assign vif2.blue_byte  = img[2][pi[2]][7:0];
  assign vif0.test_picture = tp;
  assign vif1.test_picture = tp;
  assign vif2.test_picture = tp;

  // Observed outputs: {fetch, line_repeat, fifo_reset, hsync, vsync, blank,
  //                    vblank, r, g, b}
  logic [30:0] obs0, obs1, obs2;
  assign obs0 = {vif0.fetch_next, vif0.line_repeat, vif0.fifo_reset, vif0.vga_hsync,
                 vif0.vga_vsync, vif0.vga_blank, vif0.vga_vblank, vif0.vga_r, vif0.vga_g, vif0.vga_b};
  assign obs1 = {vif1.fetch_next, vif1.line_repeat, vif1.fifo_reset, vif1.vga_hsync,
                 vif1.vga_vsync, vif1.vga_blank, vif1.vga_vblank, vif1.vga_r, vif1.vga_g, vif1.vga_b};
  assign obs2 = {vif2.fetch_next, vif2.line_repeat, vif2.fifo_reset, vif2.vga_hsync,
                 vif2.vga_vsync, vif2.vga_blank, vif2.vga_vblank, vif2.vga_r, vif2.vga_g, vif2.vga_b};

  function automatic logic [30:0] get_obs(int d);
    case (d)
      0:       return obs0;
      1:       return obs1;
      default: return obs2;
    endcase
  endfunction

  // Model state: registered outputs expected after the next clock edge.
  logic [27:0] exp_reg [ND];
  logic        ev_f [ND];
  logic        ev_l [ND];
  logic        ev_r [ND];
  int          cnt_f [ND];
  int          cnt_l [ND];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic sample_and_check();
    int   x;
    int   y;
    logic act;
    x   = t % FX;
    y   = (t / FX) % FY;
    act = (x < H_ACT) && (y < V_ACT);
    for (int d = 0; d < ND; d++) begin
      int          sx;
      int          sy;
      logic        pol;
      logic        hs_on;
      logic        vs_on;
      logic [2:0]  comb;
      logic [23:0] rgb;
      logic [30:0] o;
      sx  = cfg_sx(d);
      sy  = cfg_sy(d);
      pol = cfg_pol(d);
      o   = get_obs(d);
      if (rst) comb = 3'b000;
      else comb = {act && (x % sx == 0),
                   (x == H_ACT) && (y < V_ACT) && (y % sy != sy - 1),
                   (x == 0) && (y == V_ACT)};
      if (cyc >= -3)
        check($sformatf("dut%0d outputs", d), {1'b0, o}, {1'b0, comb, exp_reg[d]});

      if (rst) begin
        exp_reg[d] = {~pol, ~pol, 1'b1, 1'b0, 24'h0};
      end else begin
        hs_on = (x >= H_ACT + H_FP) && (x < H_ACT + H_FP + H_SYNC);
        vs_on = (y >= V_ACT + V_FP) && (y < V_ACT + V_FP + V_SYNC);
        if (!act)    rgb = 24'h0;
        else if (tp) rgb = {8'(x), 8'(y), {8{x[4] ^ y[4]}}};
        else         rgb = img[d][(y / sy) * (H_ACT / sx) + x / sx];
        exp_reg[d] = {hs_on ? pol : ~pol, vs_on ? pol : ~pol, ~act, (y >= V_ACT), rgb};
      end

      ev_f[d] = o[30];
      ev_l[d] = o[29];
      ev_r[d] = o[28];
      if (cyc >= 0 && cyc < FX * FY) begin
        cnt_f[d] += int'(o[30]);
        cnt_l[d] += int'(o[29]);
      end
    end

    // Hand-computed expectations that pin the model.
    if (cyc == -2) begin
      check("reset hsync dut2", 32'(vif2.vga_hsync), 32'd0);
      check("reset vsync dut2", 32'(vif2.vga_vsync), 32'd0);
      check("reset blank/vblank dut0", {vif0.vga_blank, vif0.vga_vblank}, 32'h2);
    end
    if (cyc == 0) check("first fetch dut0", 32'(vif0.fetch_next), 32'd1);
    if (cyc >= 1 && cyc <= 8) check("ramp vga_r dut0", 32'(vif0.vga_r), cyc);
    if (cyc == 9) check("blank vga_r dut0", {vif0.vga_blank, vif0.vga_r}, 32'h100);
    if (cyc >= 10 && cyc <= 13)
      check("hsync window dut0", 32'(vif0.vga_hsync), (cyc == 11 || cyc == 12) ? 32'd0 : 32'd1);
    if (cyc == 20)
      check("test pattern dut0", {vif0.vga_r, vif0.vga_g, vif0.vga_b}, 32'h030100);
    if (cyc == 63 || cyc == 64)
      check("fifo_reset dut0", 32'(vif0.fifo_reset), 32'(cyc == 64));
    if (cyc == 8 || cyc == 24 || cyc == 40)
      check("line_repeat dut1", 32'(vif1.line_repeat), 32'(cyc != 24));
    if (cyc == 64 || cyc == 65)
      check("vblank dut2", 32'(vif2.vga_vblank), 32'(cyc == 65));
    if (cyc == FX * FY) begin
      check("frame fetches dut0", cnt_f[0], 32'd32);
      check("frame fetches dut1", cnt_f[1], 32'd16);
      check("frame fetches dut2", cnt_f[2], 32'd8);
      check("frame line_repeats dut0", cnt_l[0], 32'd0);
      check("frame line_repeats dut1", cnt_l[1], 32'd2);
      check("frame line_repeats dut2", cnt_l[2], 32'd3);
    end
    if (cyc == 167) check("reset pulse outputs dut0", {vif0.vga_blank, vif0.vga_r}, 32'h100);
    if (cyc == 168) check("restart fetch dut0", 32'(vif0.fetch_next), 32'd1);
  endtask

  // Source and raster bookkeeping for the edge that just happened.
  task automatic advance();
    for (int d = 0; d < ND; d++) begin
      if (rst) begin
        p[d] = 0;
      end else begin
        if (ev_r[d] === 1'b1) p[d] = 0;
        if (ev_f[d] === 1'b1) p[d] = p[d] + 1;
        if (ev_l[d] === 1'b1) p[d] = p[d] - H_ACT / cfg_sx(d);
      end
      pi[d] = ((p[d] % 32) + 32) % 32;
    end
    t = rst ? 0 : t + 1;
  endtask

  // Stimulus for the upcoming cycle: a scripted opening, then random.
  task automatic drive();
    if (cyc < 300) begin
      rst = (cyc < 0) || (cyc >= 165 && cyc <= 167);
      tp  = (cyc == 19);
    end else begin
      if (rst_left == 0 && $urandom_range(0, 399) == 0) rst_left = $urandom_range(1, 3);
      rst = (rst_left > 0);
      if (rst_left > 0) rst_left--;
      if ($urandom_range(0, 15) == 0) tp = ~tp;
    end
  endtask

  initial begin
    for (int d = 0; d < ND; d++) begin
      p[d]       = 0;
      pi[d]      = 0;
      cnt_f[d]   = 0;
      cnt_l[d]   = 0;
      ev_f[d]    = 1'b0;
      ev_l[d]    = 1'b0;
      ev_r[d]    = 1'b0;
      exp_reg[d] = {~cfg_pol(d), ~cfg_pol(d), 1'b1, 1'b0, 24'h0};
      for (int k = 0; k < 32; k++) begin
        if (d == 0) img[d][k] = {8'(k + 1), 8'($urandom), 8'($urandom)};
        else        img[d][k] = 24'($urandom);
      end
    end
    while (cyc < LAST_CYC) begin
      @(negedge clk);
      sample_and_check();
      @(posedge clk);
      #1;
      advance();
      cyc++;
      drive();
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
